uart_frame_loader: RTL and testbench
====================================

Name: uart_frame_loader

Overview:
Upstream stage of the CNN pipeline. Receives a raw RGB888 image over a UART line, one pixel as 3 bytes in the order R, G, B. Writes each assembled 24-bit pixel into the input-buffer BRAM write port at sequential addresses 0..DEPTH-1. Reports frame completion so the window/conv chain can be released.

Parameters:
CLKS_PER_BIT, 434, system clocks per UART bit (50 MHz / 115200); must be ≥4.
DATA_W, 24, pixel width written to BRAM.
ADDR_W, 17, BRAM address width.
DEPTH, 130560, pixels per frame (480*272).
TIMEOUT_BITS, 32, idle bit-periods after which a partial pixel is discarded.

Ports:
iClk  input  1  system clock.
iRsn  input  1  asynchronous active-low reset.
iStart  input  1  single-cycle pulse; arms loading of a new frame.
iRx  input  1  UART serial input, idle high, 8N1, LSB first.
oWrEn  output  1  BRAM write strobe, one cycle per pixel.
oWrAddr  output  ADDR_W  BRAM write address.
oWrData  output  DATA_W  pixel {R,G,B}; R in [23:16].
oBusy  output  1  high while a frame is armed and not complete.
oFrameDone  output  1  level; high once pixel DEPTH-1 is written, cleared by iStart.
oFrameErr  output  1  sticky framing error; cleared by iStart.

Behaviour:
- Reset: all outputs 0; UART FSM IDLE; byte count 0; address 0; timeout counter 0.
- Synchroniser: iRx passes through 2 flops, reset value 1. All sampling uses the synchronised signal.
- UART RX states:
  - IDLE: on falling edge of the synchronised line -> START, bit counter cleared.
  - START: at CLKS_PER_BIT/2, sample. If high (glitch) -> IDLE; else -> DATA.
  - DATA: sample every CLKS_PER_BIT. Shift LSB-first. After 8 samples -> STOP.
  - STOP: sample after CLKS_PER_BIT. If high, the byte is valid -> IDLE. If low, the byte is discarded, oFrameErr is set, the partial pixel is dropped (byte count 0), and the FSM goes to IDLE only once the line is high.
- Byte assembly: only while oBusy=1; bytes received when oBusy=0 are ignored.
  - Byte count 0/1/2 stores R/G/B.
  - On a valid B byte: oWrData={R,G,B} and oWrEn=1 for exactly one cycle, on the clock edge after the stop-bit sample. oWrAddr holds the current address during that cycle.
  - The address increments in the cycle after oWrEn.
- Frame end: the write at address DEPTH-1 sets oFrameDone=1 and oBusy=0 in the same cycle oWrEn drops. oWrAddr wraps to 0.
- iStart:
  - Sets oBusy=1; clears oFrameDone, oFrameErr, byte count, address and timeout.
  - A byte already in flight in the RX FSM is still received and becomes byte 0 of the new frame.
  - iStart while busy restarts the frame from address 0; earlier BRAM contents are left stale.
  - iStart coincident with the final write: iStart wins (busy, address 0, done stays 0).
- Timeout: while byte count≠0, count clocks with no valid byte. At TIMEOUT_BITS*CLKS_PER_BIT clocks, byte count resets to 0 (resync). The address is unchanged and oFrameErr is not set.
- No back-pressure: BRAM accepts a write every cycle; at most one write per 30 bit-periods.
- Reset mid-frame: immediate return to reset state; a subsequent iStart is required.

Test Plan:
- Bench uses CLKS_PER_BIT=4, DEPTH=4, TIMEOUT_BITS=32.
- Single pixel: iStart, bytes 0x12,0x34,0x56 -> one oWrEn pulse, oWrAddr=0, oWrData=0x123456, address becomes 1, oBusy=1.
- Full frame: 12 bytes -> writes at addresses 0,1,2,3. oFrameDone=1 and oBusy=0 after the 4th write. A further 3 bytes produce no oWrEn.
- Framing error: send 0xAA with a low stop bit as the G byte, then 0x01,0x02,0x03 -> oFrameErr=1, next write oWrData=0x010203 at the unchanged address.
- Glitch: 1-clock low pulse on iRx while idle -> no byte, no write, FSM back in IDLE.
- Timeout: send 0x11 then idle 200 clocks, then 0x21,0x22,0x23 -> write 0x212223, not containing 0x11.
- Restart: iStart after 2 pixels -> oWrAddr restarts at 0, oFrameDone and oFrameErr both 0. Async iRsn low mid-byte -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_frame_loader.sv
// uart_frame_loader
// Receives an RGB888 image over an 8N1 UART line (3 bytes per pixel, R then G
// then B). Each assembled pixel is written to the input-buffer BRAM at
// sequential addresses 0..DEPTH-1, and frame completion is reported.
//
// Ports:
//   iClk        system clock
//   iRsn        asynchronous active-low reset
//   iStart      single-cycle pulse, arms loading of a new frame
//   iRx         UART serial input (idle high, LSB first)
//   oWrEn       BRAM write strobe, one cycle per pixel
//   oWrAddr     BRAM write address
//   oWrData     pixel {R,G,B}, R in [23:16]
//   oBusy       frame armed and not yet complete
//   oFrameDone  last pixel written; cleared by iStart
//   oFrameErr   sticky framing error; cleared by iStart
module uart_frame_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 24,
    parameter int ADDR_W       = 17,
    parameter int DEPTH        = 130560,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iStart,
    input  logic              iRx,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [DATA_W-1:0] oWrData,
    output logic              oBusy,
    output logic              oFrameDone,
    output logic              oFrameErr
);

    localparam int CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_LIMIT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK   // bad stop bit seen; wait for the line to return high
    } rx_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync;

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= iRx;
            rx_sync <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    rx_state_t        state, state_d;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_d;
    logic [2:0]       bit_cnt, bit_cnt_d;
    logic [7:0]       shift, shift_d;
    logic             byte_ok, byte_err;

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_d;
            clk_cnt <= clk_cnt_d;
            bit_cnt <= bit_cnt_d;
            shift   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state;
        clk_cnt_d = clk_cnt + CNT_W'(1);
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        byte_ok   = 1'b0;
        byte_err  = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_d = '0;
                // IDLE is only ever entered with the line high, so a low
                // level here is the falling edge of a start bit.
                if (!rx_sync) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync, shift[7:1]};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_sync) begin
                        byte_ok = 1'b1;
                        state_d = IDLE;
                    end else begin
                        byte_err = 1'b1;
                        state_d  = BREAK;
                    end
                end
            end
            BREAK: begin
                clk_cnt_d = '0;
                if (rx_sync) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel assembly, address generation, frame status
    // ------------------------------------------------------------------
    logic [1:0]       byte_cnt;
    logic [7:0]       r_byte, g_byte;
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            byte_cnt   <= '0;
            r_byte     <= '0;
            g_byte     <= '0;
            tmo_cnt    <= '0;
            oWrEn      <= 1'b0;
            oWrAddr    <= '0;
            oWrData    <= '0;
            oBusy      <= 1'b0;
            oFrameDone <= 1'b0;
            oFrameErr  <= 1'b0;
        end else begin
            oWrEn <= 1'b0;
            if (iStart) begin
                // A byte completing in this very cycle becomes byte 0 of the
                // new frame; start also overrides a coincident final write.
                oBusy      <= 1'b1;
                oFrameDone <= 1'b0;
                oFrameErr  <= 1'b0;
                oWrAddr    <= '0;
                tmo_cnt    <= '0;
                byte_cnt   <= byte_ok ? 2'd1 : 2'd0;
                if (byte_ok) begin
                    r_byte <= shift;
                end
            end else begin
                if (oWrEn) begin
                    if (oWrAddr == ADDR_LAST) begin
                        oWrAddr    <= '0;
                        oFrameDone <= 1'b1;
                        oBusy      <= 1'b0;
                    end else begin
                        oWrAddr <= oWrAddr + ADDR_W'(1);
                    end
                end

                if (oBusy && byte_ok) begin
                    tmo_cnt <= '0;
                    case (byte_cnt)
                        2'd0: begin
                            r_byte   <= shift;
                            byte_cnt <= 2'd1;
                        end
                        2'd1: begin
                            g_byte   <= shift;
                            byte_cnt <= 2'd2;
                        end
                        default: begin
                            oWrEn    <= 1'b1;
                            oWrData  <= {r_byte, g_byte, shift};
                            byte_cnt <= 2'd0;
                        end
                    endcase
                end else if (oBusy && byte_err) begin
                    oFrameErr <= 1'b1;
                    byte_cnt  <= '0;
                    tmo_cnt   <= '0;
                end else if (byte_cnt != 2'd0) begin
                    // Partial pixel with no traffic: resync after the timeout.
                    if (tmo_cnt == TMO_LAST) begin
                        byte_cnt <= '0;
                        tmo_cnt  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end else begin
                    tmo_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader. A byte-level reference model
// (pixel assembly, address, frame status) predicts every BRAM write and the
// status outputs; a monitor collects actual writes for comparison.
module tb_uart_frame_loader;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int TMO   = 32;
    localparam int AW    = 17;
    localparam int DW    = 24;

    logic          iClk   = 1'b0;
    logic          iRsn   = 1'b0;
    logic          iStart = 1'b0;
    logic          iRx    = 1'b1;
    logic          oWrEn;
    logic [AW-1:0] oWrAddr;
    logic [DW-1:0] oWrData;
    logic          oBusy;
    logic          oFrameDone;
    logic          oFrameErr;

    uart_frame_loader #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .DEPTH       (DEPTH),
        .TIMEOUT_BITS(TMO)
    ) dut (
        .iClk      (iClk),
        .iRsn      (iRsn),
        .iStart    (iStart),
        .iRx       (iRx),
        .oWrEn     (oWrEn),
        .oWrAddr   (oWrAddr),
        .oWrData   (oWrData),
        .oBusy     (oBusy),
        .oFrameDone(oFrameDone),
        .oFrameErr (oFrameErr)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    logic [AW+DW-1:0] wq[$];   // observed writes
    logic [AW+DW-1:0] eq[$];   // expected writes

    always @(negedge iClk) begin
        if (iRsn && oWrEn) wq.push_back({oWrAddr, oWrData});
    end

    // Reference model state
    bit         m_busy, m_done, m_err;
    int         m_cnt, m_addr;
    logic [7:0] m_pix[3];

    task automatic m_reset();
        m_busy = 0; m_done = 0; m_err = 0; m_cnt = 0; m_addr = 0;
    endtask

    task automatic m_start();
        m_busy = 1; m_done = 0; m_err = 0; m_cnt = 0; m_addr = 0;
    endtask

    task automatic m_byte(input logic [7:0] b, input bit ok);
        if (!m_busy) return;
        if (!ok) begin
            m_err = 1;
            m_cnt = 0;
            return;
        end
        m_pix[m_cnt] = b;
        m_cnt++;
        if (m_cnt == 3) begin
            eq.push_back({AW'(m_addr), m_pix[0], m_pix[1], m_pix[2]});
            m_cnt = 0;
            if (m_addr == DEPTH - 1) begin
                m_done = 1;
                m_busy = 0;
                m_addr = 0;
            end else begin
                m_addr++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".busy"}, 64'(oBusy), 64'(m_busy));
        chk({tag, ".done"}, 64'(oFrameDone), 64'(m_done));
        chk({tag, ".err"},  64'(oFrameErr), 64'(m_err));
        chk({tag, ".addr"}, 64'(oWrAddr), 64'(m_addr));
        chk({tag, ".wren"}, 64'(oWrEn), 64'd0);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, ".nwr"}, 64'(wq.size()), 64'(eq.size()));
        while (wq.size() > 0 && eq.size() > 0)
            chk({tag, ".wr"}, 64'(wq.pop_front()), 64'(eq.pop_front()));
        wq.delete();
        eq.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".wren"}, 64'(oWrEn), 64'd0);
        chk({tag, ".addr"}, 64'(oWrAddr), 64'd0);
        chk({tag, ".data"}, 64'(oWrData), 64'd0);
        chk({tag, ".busy"}, 64'(oBusy), 64'd0);
        chk({tag, ".done"}, 64'(oFrameDone), 64'd0);
        chk({tag, ".err"},  64'(oFrameErr), 64'd0);
    endtask

    task automatic drive_bit(input logic v);
        iRx = v;
        repeat (CPB) @(negedge iClk);
    endtask

    // Sends one 8N1 frame followed by two idle bit periods, and updates the model.
    task automatic tx(input logic [7:0] b, input bit stop_ok);
        @(negedge iClk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok ? 1'b1 : 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        m_byte(b, stop_ok);
    endtask

    task automatic tx_rand_pixels(input int n);
        for (int p = 0; p < n; p++)
            for (int k = 0; k < 3; k++) tx(8'($urandom_range(0, 255)), 1'b1);
    endtask

    task automatic pulse_start();
        @(negedge iClk);
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        m_start();
    endtask

    initial begin
        m_reset();
        repeat (3) @(negedge iClk);
        check_zero("reset");
        iRsn = 1'b1;
        repeat (3) @(negedge iClk);
        check_zero("post_reset");

        // Bytes while not armed are ignored
        tx_rand_pixels(1);
        check_writes("unarmed");
        check_state("unarmed");

        // Single pixel
        pulse_start();
        check_state("armed");
        tx(8'h12, 1'b1); tx(8'h34, 1'b1); tx(8'h56, 1'b1);
        chk("single.expected", 64'(eq[0]), {23'd0, 17'd0, 24'h123456});
        check_writes("single");
        check_state("single");

        // Full frame, then extra bytes after completion
        pulse_start();
        tx_rand_pixels(DEPTH);
        check_writes("frame");
        check_state("frame");
        tx_rand_pixels(1);
        check_writes("after_done");
        check_state("after_done");

        // Framing error on the G byte
        pulse_start();
        check_state("restart_done");
        tx(8'h77, 1'b1);
        tx(8'hAA, 1'b0);
        check_state("ferr");
        tx(8'h01, 1'b1); tx(8'h02, 1'b1); tx(8'h03, 1'b1);
        chk("ferr.expected", 64'(eq[0]), {23'd0, 17'd0, 24'h010203});
        check_writes("ferr");
        check_state("ferr_after");

        // One-clock glitch while idle
        @(negedge iClk);
        iRx = 1'b0;
        @(negedge iClk);
        iRx = 1'b1;
        repeat (40) @(negedge iClk);
        check_writes("glitch");
        check_state("glitch");

        // Partial pixel timeout
        tx(8'h11, 1'b1);
        repeat (200) @(negedge iClk);
        m_cnt = 0;
        check_state("timeout");
        tx(8'h21, 1'b1); tx(8'h22, 1'b1); tx(8'h23, 1'b1);
        chk("timeout.expected", 64'(eq[0]), {23'd0, 17'd1, 24'h212223});
        check_writes("timeout");
        check_state("timeout_after");

        // Restart mid-frame with an error flagged
        pulse_start();
        tx_rand_pixels(2);
        tx(8'h5A, 1'b0);
        check_writes("pre_restart");
        check_state("pre_restart");
        pulse_start();
        check_state("restart");
        tx_rand_pixels(DEPTH);
        check_writes("frame2");
        check_state("frame2");

        // Asynchronous reset in the middle of a byte
        pulse_start();
        tx_rand_pixels(1);
        check_writes("pre_rst");
        check_state("pre_rst");
        @(negedge iClk);
        iRx = 1'b0;
        repeat (10) @(negedge iClk);
        #2 iRsn = 1'b0;
        #1 check_zero("async_rst");
        m_reset();
        @(negedge iClk);
        iRx = 1'b1;
        repeat (4) @(negedge iClk);
        iRsn = 1'b1;
        repeat (4) @(negedge iClk);
        tx_rand_pixels(1);
        check_writes("post_rst");
        check_state("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
